// File: rtl/pc_predict.sv
// Fetch-side next-PC predictor: calls/jumps predicted taken, rets predicted from a
// circular return-address stack, with redirects from M (jxx) and W (ret) mispredicts.
module pc_predict #(
  parameter int                   ADDR_W    = 64,
  parameter int                   CODE_W    = 4,
  parameter int                   RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic                         valid,
  input  logic [CODE_W-1:0]            f_code,
  input  logic [ADDR_W-1:0]            f_valC,
  input  logic [ADDR_W-1:0]            f_valP,
  input  logic [CODE_W-1:0]            m_code,
  input  logic                         m_cnd,
  input  logic [ADDR_W-1:0]            m_valA,
  input  logic [CODE_W-1:0]            w_code,
  input  logic [ADDR_W-1:0]            w_valM,
  output logic [ADDR_W-1:0]            pred_pc,
  output logic                         f_stall,
  output logic                         redirect,
  output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
  output logic [1:0]                   dbg_state
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CODE_W-1:0] IJXX  = CODE_W'(7);
  localparam logic [CODE_W-1:0] ICALL = CODE_W'(8);
  localparam logic [CODE_W-1:0] IRET  = CODE_W'(9);

  // NORM: no ret outstanding; SPEC: one predicted ret in flight; WAIT: ret target unknown
  typedef enum logic [1:0] {ST_NORM = 2'd0, ST_SPEC = 2'd1, ST_WAIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   ret_pred_q, ret_pred_d;
  logic                redirect_q, redirect_d;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [ADDR_W-1:0]   ras_mem_q [RAS_DEPTH];

  logic [ADDR_W-1:0]   ras_top;
  logic                w_ret, ret_miss, ret_ok, ret_done, jxx_miss, fire;
  logic                push, pop, clear;

  assign ras_top  = ras_mem_q[wr_ptr_q - PTR_W'(1)];
  assign w_ret    = (w_code == IRET);
  assign ret_miss = w_ret & (state_q == ST_SPEC) & (w_valM != ret_pred_q);
  assign ret_ok   = w_ret & (state_q == ST_SPEC) & (w_valM == ret_pred_q);
  assign ret_done = w_ret & (state_q == ST_WAIT);
  assign jxx_miss = (m_code == IJXX) & ~m_cnd;
  assign f_stall  = (state_q == ST_WAIT) | ((state_q == ST_SPEC) & valid & (f_code == IRET));
  assign fire     = valid & ~f_stall;

  always_comb begin
    pc_d       = pc_q;
    state_d    = state_q;
    ret_pred_d = ret_pred_q;
    redirect_d = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    clear      = 1'b0;
    // A confirmed ret only retires SPEC; younger events still act this cycle.
    if (ret_ok) state_d = ST_NORM;
    if (ret_miss) begin
      pc_d       = w_valM;
      redirect_d = 1'b1;
      clear      = 1'b1;
      state_d    = ST_NORM;
    end else if (ret_done) begin
      pc_d    = w_valM;
      state_d = ST_NORM;
    end else if (jxx_miss) begin
      pc_d       = m_valA;
      redirect_d = 1'b1;
      clear      = 1'b1;
      state_d    = ST_NORM;
    end else if (fire) begin
      case (f_code)
        ICALL: begin
          pc_d = f_valC;
          push = 1'b1;
        end
        IJXX: pc_d = f_valC;
        IRET: begin
          if (cnt_q != '0) begin
            pc_d       = ras_top;
            ret_pred_d = ras_top;
            pop        = 1'b1;
            state_d    = ST_SPEC;
          end else begin
            state_d = ST_WAIT;
          end
        end
        default: pc_d = f_valP;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q    <= ST_NORM;
      pc_q       <= RESET_PC;
      ret_pred_q <= '0;
      redirect_q <= 1'b0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ret_pred_q <= ret_pred_d;
      redirect_q <= redirect_d;
      if (clear) begin
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else if (push) begin
        // Full stack: oldest entry is overwritten, count saturates.
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (cnt_q != CNT_W'(RAS_DEPTH)) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        wr_ptr_q <= wr_ptr_q - PTR_W'(1);
        cnt_q    <= cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push && !rst) ras_mem_q[wr_ptr_q] <= f_valP;
  end

  assign pred_pc   = pc_q;
  assign redirect  = redirect_q;
  assign ras_cnt   = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pc_predict.sv
// Bench for pc_predict: vector table of fetch/M/W inputs with expected PC, redirect,
// RAS count and state, followed by RAS saturation and mid-run reset sequences.
module tb_pc_predict;

  localparam int AW    = 64;
  localparam int CNT_W = 4;
  localparam int W     = AW + 1 + CNT_W + 2;
  localparam logic [3:0] INOP = 4'h1, IJXX = 4'h7, ICALL = 4'h8, IRET = 4'h9;
  localparam logic [1:0] S_NORM = 2'd0, S_SPEC = 2'd1, S_WAIT = 2'd2;

  logic             sys_clk = 1'b0;
  logic             rst, valid, m_cnd;
  logic [3:0]       f_code, m_code, w_code;
  logic [AW-1:0]    f_valC, f_valP, m_valA, w_valM;
  logic [AW-1:0]    pred_pc;
  logic             f_stall, redirect;
  logic [CNT_W-1:0] ras_cnt;
  logic [1:0]       dbg_state;

  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic rst; logic valid;
    logic [3:0] f_code; logic [AW-1:0] f_valC; logic [AW-1:0] f_valP;
    logic [3:0] m_code; logic m_cnd; logic [AW-1:0] m_valA;
    logic [3:0] w_code; logic [AW-1:0] w_valM;
    logic exp_stall; logic [AW-1:0] exp_pc; logic exp_redir;
    logic [CNT_W-1:0] exp_cnt; logic [1:0] exp_state;
  } vec_t;

  pc_predict dut (
    .sys_clk(sys_clk), .rst(rst), .valid(valid),
    .f_code(f_code), .f_valC(f_valC), .f_valP(f_valP),
    .m_code(m_code), .m_cnd(m_cnd), .m_valA(m_valA),
    .w_code(w_code), .w_valM(w_valM),
    .pred_pc(pred_pc), .f_stall(f_stall), .redirect(redirect),
    .ras_cnt(ras_cnt), .dbg_state(dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input logic v, input logic [3:0] fc, input logic [AW-1:0] fvc,
                              input logic [AW-1:0] fvp, input logic [3:0] mc, input logic mcnd,
                              input logic [AW-1:0] mva, input logic [3:0] wc,
                              input logic [AW-1:0] wvm, input logic stall,
                              input logic [AW-1:0] pc, input logic redir,
                              input logic [CNT_W-1:0] cnt, input logic [1:0] st);
    vec_t r;
    r.rst = 1'b0; r.valid = v;
    r.f_code = fc; r.f_valC = fvc; r.f_valP = fvp;
    r.m_code = mc; r.m_cnd = mcnd; r.m_valA = mva;
    r.w_code = wc; r.w_valM = wvm;
    r.exp_stall = stall; r.exp_pc = pc; r.exp_redir = redir;
    r.exp_cnt = cnt; r.exp_state = st;
    return r;
  endfunction

  function automatic vec_t fv(input logic [3:0] fc, input logic [AW-1:0] fvc,
                              input logic [AW-1:0] fvp, input logic stall,
                              input logic [AW-1:0] pc, input logic redir,
                              input logic [CNT_W-1:0] cnt, input logic [1:0] st);
    return mk(1'b1, fc, fvc, fvp, INOP, 1'b0, '0, INOP, '0, stall, pc, redir, cnt, st);
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One cycle: drive, check combinational stall, push expectation, pop after the edge.
  task automatic step(input vec_t v);
    logic [W-1:0] e;
    rst = v.rst; valid = v.valid;
    f_code = v.f_code; f_valC = v.f_valC; f_valP = v.f_valP;
    m_code = v.m_code; m_cnd = v.m_cnd; m_valA = v.m_valA;
    w_code = v.w_code; w_valM = v.w_valM;
    #1;
    check("f_stall", {63'd0, f_stall}, {63'd0, v.exp_stall});
    exp_q.push_back({v.exp_pc, v.exp_redir, v.exp_cnt, v.exp_state});
    @(posedge sys_clk);
    #1;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      e = exp_q.pop_front();
      check("pred_pc",  pred_pc,              e[W-1 -: AW]);
      check("redirect", {63'd0, redirect},    {63'd0, e[CNT_W+2]});
      check("ras_cnt",  {60'd0, ras_cnt},     {60'd0, e[CNT_W+1 -: CNT_W]});
      check("state",    {62'd0, dbg_state},   {62'd0, e[1:0]});
    end
  endtask

  localparam int NVEC = 29;
  vec_t vecs [NVEC];

  initial begin
    vec_t v;
    // straight-line
    vecs[0]  = fv(INOP,  64'h0,   64'h0A,  0, 64'h0A,  0, 0, S_NORM);
    vecs[1]  = fv(INOP,  64'h0,   64'h14,  0, 64'h14,  0, 0, S_NORM);
    // call/ret, correct prediction
    vecs[2]  = fv(ICALL, 64'h100, 64'h20,  0, 64'h100, 0, 1, S_NORM);
    vecs[3]  = fv(IRET,  64'h0,   64'h21,  0, 64'h20,  0, 0, S_SPEC);
    vecs[4]  = fv(INOP,  64'h0,   64'h24,  0, 64'h24,  0, 0, S_SPEC);
    vecs[5]  = fv(IRET,  64'h0,   64'h25,  1, 64'h24,  0, 0, S_SPEC);
    vecs[6]  = mk(0, IRET, 64'h0, 64'h0, INOP, 0, 64'h0, IRET, 64'h20, 0, 64'h24, 0, 0, S_NORM);
    // ret mispredict clears a non-empty RAS and drops the fetch
    vecs[7]  = fv(ICALL, 64'h100, 64'h20,  0, 64'h100, 0, 1, S_NORM);
    vecs[8]  = fv(ICALL, 64'h300, 64'h104, 0, 64'h300, 0, 2, S_NORM);
    vecs[9]  = fv(IRET,  64'h0,   64'h301, 0, 64'h104, 0, 1, S_SPEC);
    vecs[10] = mk(1, INOP, 64'h0, 64'h108, INOP, 0, 64'h0, IRET, 64'h44, 0, 64'h44, 1, 0, S_NORM);
    vecs[11] = fv(INOP,  64'h0,   64'h48,  0, 64'h48,  0, 0, S_NORM);
    // ret with empty RAS waits for W
    vecs[12] = fv(IRET,  64'h0,   64'h49,  0, 64'h48,  0, 0, S_WAIT);
    vecs[13] = fv(IRET,  64'h0,   64'h49,  1, 64'h48,  0, 0, S_WAIT);
    vecs[14] = mk(1, IRET, 64'h0, 64'h49, INOP, 0, 64'h0, IRET, 64'h80, 1, 64'h80, 0, 0, S_NORM);
    vecs[15] = fv(INOP,  64'h0,   64'h84,  0, 64'h84,  0, 0, S_NORM);
    // jxx mispredict, taken jxx in M is harmless
    vecs[16] = fv(IJXX,  64'h200, 64'h88,  0, 64'h200, 0, 0, S_NORM);
    vecs[17] = fv(ICALL, 64'h400, 64'h204, 0, 64'h400, 0, 1, S_NORM);
    vecs[18] = mk(1, INOP, 64'h0, 64'h404, IJXX, 0, 64'h30, INOP, 64'h0, 0, 64'h30, 1, 0, S_NORM);
    vecs[19] = mk(1, INOP, 64'h0, 64'h34,  IJXX, 1, 64'h99, INOP, 64'h0, 0, 64'h34, 0, 0, S_NORM);
    // ret mispredict wins over jxx mispredict
    vecs[20] = fv(ICALL, 64'h100, 64'h38,  0, 64'h100, 0, 1, S_NORM);
    vecs[21] = fv(IRET,  64'h0,   64'h101, 0, 64'h38,  0, 0, S_SPEC);
    vecs[22] = mk(0, INOP, 64'h0, 64'h0, IJXX, 0, 64'h60, IRET, 64'h50, 0, 64'h50, 1, 0, S_NORM);
    vecs[23] = mk(0, INOP, 64'h0, 64'h0, INOP, 0, 64'h0,  INOP, 64'h0,  0, 64'h50, 0, 0, S_NORM);
    // ret confirmed while jxx mispredicts: jxx still redirects
    vecs[24] = fv(ICALL, 64'h100, 64'h70,  0, 64'h100, 0, 1, S_NORM);
    vecs[25] = fv(IRET,  64'h0,   64'h101, 0, 64'h70,  0, 0, S_SPEC);
    vecs[26] = mk(0, INOP, 64'h0, 64'h0, IJXX, 0, 64'h90, IRET, 64'h70, 0, 64'h90, 1, 0, S_NORM);
    vecs[27] = mk(0, INOP, 64'h0, 64'h0, INOP, 0, 64'h0,  INOP, 64'h0,  0, 64'h90, 0, 0, S_NORM);
    // valid low: fetch inputs ignored
    vecs[28] = mk(0, ICALL, 64'h500, 64'h600, INOP, 0, 64'h0, INOP, 64'h0, 0, 64'h90, 0, 0, S_NORM);

    rst = 1'b1; valid = 1'b0; m_cnd = 1'b0;
    f_code = INOP; m_code = INOP; w_code = INOP;
    f_valC = '0; f_valP = '0; m_valA = '0; w_valM = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    check("reset pred_pc",  pred_pc, 64'h0);
    check("reset redirect", {63'd0, redirect}, 64'h0);
    check("reset ras_cnt",  {60'd0, ras_cnt}, 64'h0);
    check("reset state",    {62'd0, dbg_state}, {62'd0, S_NORM});
    check("reset f_stall",  {63'd0, f_stall}, 64'h0);

    for (int i = 0; i < NVEC; i++) step(vecs[i]);

    // RAS overflow: 9 calls into 8 entries, then rets pop 9..2 and the last waits
    for (int i = 1; i <= 9; i++)
      step(fv(ICALL, 64'h1000 + 64'(i), 64'(i), 0, 64'h1000 + 64'(i), 0,
              CNT_W'(i > 8 ? 8 : i), S_NORM));
    for (int k = 1; k <= 8; k++) begin
      step(fv(IRET, 64'h0, 64'hF00, 0, 64'(10 - k), 0, CNT_W'(8 - k), S_SPEC));
      step(mk(0, INOP, 64'h0, 64'h0, INOP, 0, 64'h0, IRET, 64'(10 - k), 0,
              64'(10 - k), 0, CNT_W'(8 - k), S_NORM));
    end
    step(fv(IRET, 64'h0, 64'hF00, 0, 64'h2, 0, 0, S_WAIT));
    step(fv(IRET, 64'h0, 64'hF00, 1, 64'h2, 0, 0, S_WAIT));

    // reset from WAIT
    v = fv(IRET, 64'h0, 64'hF00, 1, 64'h0, 0, 0, S_NORM);
    v.rst = 1'b1;
    step(v);
    step(fv(INOP, 64'h0, 64'h10, 0, 64'h10, 0, 0, S_NORM));

    if (exp_q.size() != 0) begin
      total++;
      $display("FAIL scoreboard: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
